instr_fetch_unit: RTL and testbench

//   Instruction-fetch front end feeding the decode stage of the 4-stage pipeline.

---
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction-fetch front end for the 4-stage pipeline. Owns the PC, a
//   synchronous-read instruction memory and a small prefetch FIFO, and hands
//   {pc, instr} pairs to decode over a valid/ready handshake. Supports branch
//   redirects (which flush everything in flight) and a program-load write port.
//
// Ports
//   clk             sole clock, rising edge
//   reset_n         synchronous, active-low reset
//   fetch_en        1 = issue fetches, 0 = hold PC
//   imem_we         program-load write strobe (honoured during reset)
//   imem_waddr      program-load write address
//   imem_wdata      program-load write data
//   redirect_valid  one-cycle redirect pulse
//   redirect_pc     redirect target
//   if_ready        decode can accept
//   if_valid        FIFO head valid
//   if_instr        instruction at FIFO head
//   if_pc           address of if_instr
//   perf_fetch_cnt  (IFU_PERF_CNT_EN only) saturating transfer count
//   perf_stall_cnt  (IFU_PERF_CNT_EN only) saturating valid-but-not-ready count
//
// Build option
//   IFU_PERF_CNT_EN  adds the two 16-bit performance counters.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Instruction memory: no reset, registered read.
  logic [DATA_W-1:0] imem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] rdata_reg;

  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [ADDR_W-1:0] fifo_pc    [0:DEPTH-1];
  logic [DATA_W-1:0] fifo_instr [0:DEPTH-1];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occ_after_pop;

  assign if_valid = (count_reg != '0);
  assign if_pc    = fifo_pc[rd_ptr_reg];
  assign if_instr = fifo_instr[rd_ptr_reg];

  assign pop  = if_valid && if_ready;
  assign push = inflight_reg && !redirect_valid;

  // Credit check counts the slot being freed by a pop on this same edge, so a
  // two-entry FIFO still streams one instruction per clock. Without a pop this
  // reduces to count + inflight < DEPTH, so the FIFO can never overflow.
  assign occ_after_pop = {1'b0, count_reg}
                       + {{CNT_W{1'b0}}, inflight_reg}
                       - {{CNT_W{1'b0}}, pop};

  assign issue = reset_n && fetch_en && !redirect_valid &&
                 (occ_after_pop < (CNT_W+1)'(DEPTH));

  // Write and read share one block so a same-address collision returns the
  // old word (read-before-write).
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
    if (issue) begin
      rdata_reg <= imem[pc_reg];
    end
  end

  // PC, in-flight tracking and FIFO bookkeeping. Redirect dominates all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg          <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (redirect_valid) begin
      pc_reg       <= redirect_pc;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg          <= pc_reg + 1'b1;
        inflight_pc_reg <= pc_reg;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage, one register pair per entry. Entries reset to zero so the
  // head reads {0,0} after reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0] pc_q;
      logic [DATA_W-1:0] instr_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          pc_q    <= '0;
          instr_q <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_q    <= inflight_pc_reg;
          instr_q <= rdata_reg;
        end
      end

      assign fifo_pc[gi]    = pc_q;
      assign fifo_instr[gi] = instr_q;
    end
  endgenerate

`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt_reg;
  logic [15:0] perf_stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetch_cnt_reg <= '0;
      perf_stall_cnt_reg <= '0;
    end else begin
      if (pop && (perf_fetch_cnt_reg != 16'hFFFF)) begin
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 16'd1;
      end
      if (if_valid && !if_ready && (perf_stall_cnt_reg != 16'hFFFF)) begin
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 16'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. Expected {pc, instr} pairs are queued
//   as stimulus is issued; a negedge monitor pops and compares on each transfer.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk;
  logic              reset_n;
  logic              fetch_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]       perf_fetch_cnt;
  logic [15:0]       perf_stall_cnt;
`endif

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("[TB] ok   %s value=%0h", name, act);
    end
  endtask

  task automatic expect_xfer(input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] d);
    exp_q.push_back({p, d});
  endtask

  // Advance one edge; inputs change and checks happen 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    step();
    imem_we    = 1'b0;
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // Monitor: the state seen at negedge is what the next posedge transfers.
  always @(negedge clk) begin
    if (reset_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL xfer_unexpected actual=(%0h,%0h) required=none", if_pc, if_instr);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("xfer", {20'd0, if_pc, if_instr}, {20'd0, e});
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    imem_we        = 1'b0;
    imem_waddr     = '0;
    imem_wdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Program load under reset.
    step();
    write_mem(4'h0, 8'h01);
    write_mem(4'h1, 8'h12);
    write_mem(4'h2, 8'h23);
    write_mem(4'h3, 8'h34);
    write_mem(4'hE, 8'hEE);
    write_mem(4'hF, 8'hAA);
    check("reset_valid", {31'd0, if_valid}, 32'd0);
    check("reset_pc",    {28'd0, if_pc},    32'd0);
    check("reset_instr", {24'd0, if_instr}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("reset_perf_fetch", {16'd0, perf_fetch_cnt}, 32'd0);
    check("reset_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif

    // 1: release reset and stream three words on consecutive cycles.
    expect_xfer(4'h0, 8'h01);
    expect_xfer(4'h1, 8'h12);
    expect_xfer(4'h2, 8'h23);
    reset_n  = 1'b1;
    fetch_en = 1'b1;
    if_ready = 1'b1;
    step();                                   // first issue edge
    check("t1_valid_e0", {31'd0, if_valid}, 32'd0);
    step();
    check("t1_valid_e1", {31'd0, if_valid}, 32'd1);
    check("t1_head_pc",  {28'd0, if_pc},    32'd0);
    step();                                   // issues pc=2, delivers pc=0
    fetch_en = 1'b0;
    step();
    step();
    check("t1_drained", {31'd0, if_valid}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // 2: back-pressure fills the FIFO; release delivers in order.
    if_ready = 1'b0;
    fetch_en = 1'b1;
    do_redirect(4'h0);
    repeat (6) step();
    check("t2_full_valid", {31'd0, if_valid}, 32'd1);
    check("t2_full_head",  {20'd0, if_pc, if_instr}, {20'd0, 4'h0, 8'h01});
    expect_xfer(4'h0, 8'h01);
    expect_xfer(4'h1, 8'h12);
    expect_xfer(4'h2, 8'h23);
    if_ready = 1'b1;
    step();                                   // pop pc=0, issue pc=2
    fetch_en = 1'b0;
    step();
    step();
    check("t2_drained", {31'd0, if_valid}, 32'd0);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // 3: redirect to E while full flushes both entries.
    if_ready = 1'b0;
    fetch_en = 1'b1;
    do_redirect(4'h0);
    repeat (3) step();
    check("t3_full_valid", {31'd0, if_valid}, 32'd1);
    do_redirect(4'hE);
    check("t3_flushed", {31'd0, if_valid}, 32'd0);
    expect_xfer(4'hE, 8'hEE);
    if_ready = 1'b1;
    step();                                   // issue pc=E
    fetch_en = 1'b0;
    check("t3_valid_r1", {31'd0, if_valid}, 32'd0);
    step();
    check("t3_valid_r2", {31'd0, if_valid}, 32'd1);
    check("t3_head", {20'd0, if_pc, if_instr}, {20'd0, 4'hE, 8'hEE});
    step();
    check("t3_queue_empty", exp_q.size(), 32'd0);

    // 4: PC wrap F -> 0.
    expect_xfer(4'hF, 8'hAA);
    expect_xfer(4'h0, 8'h01);
    fetch_en = 1'b1;
    do_redirect(4'hF);
    step();                                   // issue F
    step();                                   // issue 0
    fetch_en = 1'b0;
    step();
    step();
    check("t4_drained", {31'd0, if_valid}, 32'd0);
    check("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: write/read collision on address 3.
    expect_xfer(4'h3, 8'h34);
    fetch_en = 1'b1;
    do_redirect(4'h3);
    imem_we    = 1'b1;
    imem_waddr = 4'h3;
    imem_wdata = 8'h5A;
    step();                                   // issue pc=3 + write
    imem_we  = 1'b0;
    fetch_en = 1'b0;
    step();
    step();
    check("t5_old_queue_empty", exp_q.size(), 32'd0);
    expect_xfer(4'h3, 8'h5A);
    fetch_en = 1'b1;
    do_redirect(4'h3);
    step();
    fetch_en = 1'b0;
    step();
    step();
    check("t5_new_queue_empty", exp_q.size(), 32'd0);

    // 6: reset mid-stream discards everything and restarts at pc=0.
    expect_xfer(4'h0, 8'h01);
    expect_xfer(4'h1, 8'h12);
    fetch_en = 1'b1;
    do_redirect(4'h0);
    repeat (4) step();
    reset_n = 1'b0;
    step();
    check("t6_reset_valid", {31'd0, if_valid}, 32'd0);
    check("t6_reset_head",  {20'd0, if_pc, if_instr}, 32'd0);
    check("t6_queue_empty", exp_q.size(), 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("t6_perf_fetch", {16'd0, perf_fetch_cnt}, 32'd0);
    check("t6_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif
    expect_xfer(4'h0, 8'h01);
    reset_n = 1'b1;
    step();                                   // issue pc=0
    fetch_en = 1'b0;
    step();
    step();
    check("t6_restart_drained", {31'd0, if_valid}, 32'd0);
    check("t6_restart_queue_empty", exp_q.size(), 32'd0);
`ifdef IFU_PERF_CNT_EN
    check("t6_perf_fetch_after", {16'd0, perf_fetch_cnt}, 32'd1);
    check("t6_perf_stall_after", {16'd0, perf_stall_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
